weight_tile_loader: RTL and testbench
=====================================

WEIGHT_TILE_LOADER -- requirements
Module: weight_tile_loader

Interface
REQ-001 SHALL have these ports: clk_i, input, 1, clock; all state updates on rising edge.
REQ-002 SHALL have these ports: rst_i, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have these ports: start_i, input, 1, job start pulse; sampled only in IDLE.
REQ-004 SHALL have these ports: W_tiles_i, input, 6, number of weight tiles in job; sampled with start_i.
REQ-005 SHALL have these ports: W_base_addr_i, input, 16, weight memory base row address; sampled with start_i.
REQ-006 SHALL have these ports: weight_mem_rd_en_o, output, 1, weight memory read strobe.
REQ-007 SHALL have these ports: weight_mem_addr_o, output, 16, weight memory row address.
REQ-008 SHALL have these ports: weight_mem_data_i, input, MUL_SIZE*8, read data; valid exactly 1 cycle after rd_en.
REQ-009 SHALL have these ports: load_weight_row_o, output, 1, write strobe into MAC shadow weight buffer.
REQ-010 SHALL have these ports: load_weight_buf_o, output, 1, target shadow buffer (0/1).
REQ-011 SHALL have these ports: load_weight_row_sel_o, output, 5, target row index.
REQ-012 SHALL have these ports: load_weight_data_o, output, MUL_SIZE*8, row data (weight_mem_data_i passed through).
REQ-013 SHALL have these ports: next_weight_tile_i, input, 1, consumer pulse releasing the active tile.
REQ-014 SHALL have these ports: compute_weights_rdy_o, output, 1, active shadow buffer holds a complete tile.
REQ-015 SHALL have these ports: busy_o, output, 1, high in any state except IDLE.
REQ-016 SHALL have these ports: done_o, output, 1, one-cycle pulse on job completion.

Function
REQ-017 SHALL implement states IDLE, FETCH, WAIT_SLOT, DRAIN, DONE.
REQ-018 SHALL keep per-buffer full flags full[0:1], write pointer wr_buf, read pointer rd_buf, row counter (5 b), tiles-issued and tiles-consumed counters (6 b each), and a 16-bit address register.
REQ-019 IDLE: on start_i with W_tiles_i!=0, latch inputs, clear counters and pointers, and go to FETCH; with W_tiles_i==0, go to DONE without any memory read.
REQ-020 FETCH: while full[wr_buf]==0, assert weight_mem_rd_en_o each cycle at address W_base + tile*MUL_SIZE + row, with row incrementing 0..MUL_SIZE-1 and no bubbles inside a tile.
REQ-021 SHALL drive load_weight_row_o, load_weight_buf_o and load_weight_row_sel_o as the 1-cycle-delayed copies of the read strobe, wr_buf and row.
REQ-022 The edge that writes row MUL_SIZE-1 SHALL set full[wr_buf], toggle wr_buf and increment tiles-issued.
REQ-023 After the last row issue, FETCH SHALL go to DRAIN if tiles-issued+1==W_tiles, else to WAIT_SLOT when the next slot is full, else stay in FETCH with row restarted at 0 back-to-back.
REQ-024 WAIT_SLOT SHALL return to FETCH the cycle after full[wr_buf] clears.
REQ-025 compute_weights_rdy_o SHALL equal full[rd_buf] (combinational from flags).
REQ-026 next_weight_tile_i with compute_weights_rdy_o high SHALL clear full[rd_buf], toggle rd_buf and increment tiles-consumed; when compute_weights_rdy_o is low it SHALL be ignored.
REQ-027 Fill-complete and release on the same edge SHALL both take effect (different buffers; no lost update).
REQ-028 DRAIN SHALL go to DONE when tiles-consumed reaches W_tiles.
REQ-029 DONE SHALL assert done_o for exactly one cycle, then go to IDLE.
REQ-030 start_i outside IDLE SHALL be ignored.
REQ-031 Address arithmetic SHALL be modulo 2^16 (wrap, no error).

Reset
REQ-032 While rst_i is high (asynchronously, mid-job included), the block SHALL force state to IDLE, all flags, counters and pointers to 0, and all outputs to 0, including compute_weights_rdy_o, busy_o, done_o, rd_en and load_weight_row_o.
REQ-033 SHALL start no activity until a start_i pulse arrives after rst_i deasserts.

Structure
REQ-034 MUL_SIZE (32), the state enum and the weight-row data width SHALL be defined in tpu_package.
REQ-035 SHALL be a single module with no sub-modules; the slot-flag logic SHALL be a natural candidate for a 2-entry tile-slot tracker if reused.

Verification
REQ-036 Start, base 0x0100, 1 tile, no consumer pulse -> 32 reads at 0x0100..0x011F, rdy high on the cycle after the last row write, DRAIN held; one next_weight_tile pulse -> done_o pulses 2 cycles later.
REQ-037 3 tiles with the consumer stalled -> 64 back-to-back reads, then WAIT_SLOT with no reads; first release -> reads resume at base+64.
REQ-038 W_tiles=0 -> done_o pulses on the second cycle after start, with zero reads.
REQ-039 Base 0xFFF0, 1 tile -> addresses wrap 0xFFF0..0x000F.
REQ-040 rst_i asserted at row 10 of tile 1 -> all outputs 0 immediately (asynchronous); a subsequent start begins again at the base address.
REQ-041 Release coinciding with the last-row write of the other buffer -> rdy stays high, both full flags correct, and no tile is skipped or duplicated.

Source files
------------

// File: rtl/weight_tile_loader_pkg.sv
// Shared types and sizing for the weight tile loader.
package weight_tile_loader_pkg;

  // Rows per weight tile; also the MAC array width in bytes.
  localparam int unsigned MulSize  = 32;
  localparam int unsigned RowW     = MulSize * 8;
  localparam int unsigned RowSelW  = 5;
  localparam int unsigned TileCntW = 6;
  localparam int unsigned AddrW    = 16;

  typedef logic [RowW-1:0] row_data_t;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWaitSlot,
    StDrain,
    StDone
  } wtl_state_e;

endpackage

// File: rtl/weight_tile_loader_if.sv
// Weight memory read port plus MAC shadow-buffer write port.
interface weight_tile_loader_if;
  import weight_tile_loader_pkg::*;

  logic                weight_mem_rd_en_o;
  logic [AddrW-1:0]    weight_mem_addr_o;
  row_data_t           weight_mem_data_i;
  logic                load_weight_row_o;
  logic                load_weight_buf_o;
  logic [RowSelW-1:0]  load_weight_row_sel_o;
  row_data_t           load_weight_data_o;

  // Loader side.
  modport master (
    output weight_mem_rd_en_o,
    output weight_mem_addr_o,
    input  weight_mem_data_i,
    output load_weight_row_o,
    output load_weight_buf_o,
    output load_weight_row_sel_o,
    output load_weight_data_o
  );

  // Memory / MAC side.
  modport slave (
    input  weight_mem_rd_en_o,
    input  weight_mem_addr_o,
    output weight_mem_data_i,
    input  load_weight_row_o,
    input  load_weight_buf_o,
    input  load_weight_row_sel_o,
    input  load_weight_data_o
  );

endinterface

// File: rtl/weight_tile_loader.sv
// Streams W_tiles weight tiles of MulSize rows into a double-buffered MAC shadow store
// and hands complete tiles to the consumer one at a time.
module weight_tile_loader
  import weight_tile_loader_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [TileCntW-1:0]  W_tiles_i,
  input  logic [AddrW-1:0]     W_base_addr_i,
  input  logic                 next_weight_tile_i,
  output logic                 compute_weights_rdy_o,
  output logic                 busy_o,
  output logic                 done_o,
  weight_tile_loader_if.master bus_io
);

  localparam logic [RowSelW-1:0] LastRow = RowSelW'(MulSize - 1);

  wtl_state_e          state_q;
  logic [1:0]          full_q, full_d;
  logic                wr_buf_q, rd_buf_q;
  // Buffer targeted by reads being issued; runs one tile ahead of wr_buf_q because
  // the next tile's first read overlaps the previous tile's last write.
  logic                iss_buf_q;
  logic [RowSelW-1:0]  row_q;
  logic [TileCntW-1:0] issued_q, issued_d, consumed_q, consumed_d, tiles_q;
  logic [AddrW-1:0]    addr_q;
  logic                rd_en_q, ld_row_q, ld_buf_q;
  logic [RowSelW-1:0]  ld_sel_q;
  logic                busy_q, done_q;
  logic                tile_fill, tile_release;

  // Slot tracker: fill and release hit different buffers, so both apply on one edge.
  always_comb begin
    tile_fill    = ld_row_q && (ld_sel_q == LastRow);
    tile_release = next_weight_tile_i && full_q[rd_buf_q];
    full_d       = full_q;
    if (tile_fill)    full_d[wr_buf_q] = 1'b1;
    if (tile_release) full_d[rd_buf_q] = 1'b0;
    issued_d   = tile_fill    ? issued_q + TileCntW'(1)   : issued_q;
    consumed_d = tile_release ? consumed_q + TileCntW'(1) : consumed_q;
  end

  // Control FSM, slot flags, counters and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      full_q     <= '0;
      wr_buf_q   <= 1'b0;
      rd_buf_q   <= 1'b0;
      iss_buf_q  <= 1'b0;
      row_q      <= '0;
      issued_q   <= '0;
      consumed_q <= '0;
      tiles_q    <= '0;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      ld_row_q   <= 1'b0;
      ld_buf_q   <= 1'b0;
      ld_sel_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      full_q     <= full_d;
      issued_q   <= issued_d;
      consumed_q <= consumed_d;
      if (tile_fill)    wr_buf_q <= ~wr_buf_q;
      if (tile_release) rd_buf_q <= ~rd_buf_q;
      // Write strobe trails the read by the memory's one-cycle latency.
      ld_row_q <= rd_en_q;
      ld_buf_q <= iss_buf_q;
      ld_sel_q <= row_q;
      done_q   <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            tiles_q    <= W_tiles_i;
            addr_q     <= W_base_addr_i;
            full_q     <= '0;
            wr_buf_q   <= 1'b0;
            rd_buf_q   <= 1'b0;
            iss_buf_q  <= 1'b0;
            row_q      <= '0;
            issued_q   <= '0;
            consumed_q <= '0;
            busy_q     <= 1'b1;
            if (W_tiles_i != '0) begin
              state_q <= StFetch;
              rd_en_q <= 1'b1;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StFetch: begin
          // Tiles are contiguous, so the address is a running row counter.
          addr_q <= addr_q + AddrW'(1);
          if (row_q == LastRow) begin
            row_q     <= '0;
            iss_buf_q <= ~iss_buf_q;
            if (issued_q + TileCntW'(1) == tiles_q) begin
              state_q <= StDrain;
              rd_en_q <= 1'b0;
            end else if (full_q[~iss_buf_q]) begin
              state_q <= StWaitSlot;
              rd_en_q <= 1'b0;
            end
          end else begin
            row_q <= row_q + RowSelW'(1);
          end
        end
        StWaitSlot: begin
          if (!full_q[iss_buf_q]) begin
            state_q <= StFetch;
            rd_en_q <= 1'b1;
          end
        end
        StDrain: begin
          if (consumed_d == tiles_q) state_q <= StDone;
        end
        StDone: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign compute_weights_rdy_o        = full_q[rd_buf_q];
  assign busy_o                       = busy_q;
  assign done_o                       = done_q;
  assign bus_io.weight_mem_rd_en_o    = rd_en_q;
  assign bus_io.weight_mem_addr_o     = addr_q;
  assign bus_io.load_weight_row_o     = ld_row_q;
  assign bus_io.load_weight_buf_o     = ld_buf_q;
  assign bus_io.load_weight_row_sel_o = ld_sel_q;
  assign bus_io.load_weight_data_o    = ld_row_q ? bus_io.weight_mem_data_i : '0;

endmodule

// File: tb/tb_weight_tile_loader.sv
// Self-checking bench for weight_tile_loader with a behavioural memory and shadow-buffer model.
module tb_weight_tile_loader;
  import weight_tile_loader_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start;
  logic [5:0]  w_tiles;
  logic [15:0] w_base;
  logic        next_tile;
  logic        rdy, busy, done;

  weight_tile_loader_if u_if ();

  weight_tile_loader dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .start_i               (start),
    .W_tiles_i             (w_tiles),
    .W_base_addr_i         (w_base),
    .next_weight_tile_i    (next_tile),
    .compute_weights_rdy_o (rdy),
    .busy_o                (busy),
    .done_o                (done),
    .bus_io                (u_if)
  );

  always #5 clk_i = ~clk_i;

  function automatic row_data_t pat(input logic [15:0] a);
    return {8{a, a ^ 16'hA5C3}};
  endfunction

  // Weight memory: data valid one cycle after the read strobe.
  row_data_t mem_q;
  always_ff @(posedge clk_i) mem_q <= u_if.weight_mem_rd_en_o ? pat(u_if.weight_mem_addr_o) : '0;
  assign u_if.weight_mem_data_i = mem_q;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          sc;
  logic [15:0] base;
  logic [15:0] rd_log[$];
  int          rd_cyc[$];
  row_data_t   shadow[2][MulSize];
  logic        sv[2][MulSize];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample on the falling edge and record reads and buffer writes.
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
    if (u_if.weight_mem_rd_en_o === 1'b1) begin
      rd_log.push_back(u_if.weight_mem_addr_o);
      rd_cyc.push_back(cyc);
    end
    if (u_if.load_weight_row_o === 1'b1) begin
      shadow[u_if.load_weight_buf_o][u_if.load_weight_row_sel_o] = u_if.load_weight_data_o;
      sv[u_if.load_weight_buf_o][u_if.load_weight_row_sel_o] = 1'b1;
    end
  endtask

  task automatic kick(input logic [15:0] b, input logic [5:0] w);
    base = b;
    rd_log.delete();
    rd_cyc.delete();
    for (int k = 0; k < 2; k++) for (int r = 0; r < MulSize; r++) sv[k][r] = 1'b0;
    w_base  = b;
    w_tiles = w;
    start   = 1'b1;
    sc      = cyc;
    tick();
    start   = 1'b0;
  endtask

  // Tile t must sit in buffer t%2 with rows base+t*MulSize+r.
  task automatic check_tile(input int t);
    int errs;
    int b;
    errs = 0;
    b = t % 2;
    for (int r = 0; r < MulSize; r++) begin
      if (!sv[b][r] || shadow[b][r] !== pat(16'(base + 16'(t * MulSize + r)))) errs++;
      sv[b][r] = 1'b0;
    end
    check("tile_content", errs, 0);
  endtask

  task automatic check_reads(input int w, input string tag);
    int bad;
    int gaps;
    bad = 0;
    gaps = 0;
    check({tag, "_nreads"}, rd_log.size(), w * MulSize);
    foreach (rd_log[i]) begin
      if (rd_log[i] !== 16'(base + 16'(i))) bad++;
      if ((i % MulSize) != 0 && rd_cyc[i] != rd_cyc[i-1] + 1) gaps++;
    end
    check({tag, "_addr_seq"}, bad, 0);
    check({tag, "_no_bubble"}, gaps, 0);
  endtask

  // Consume tiles as they become ready; done must pulse two cycles after the last release.
  task automatic drain(input int w, input int cons0);
    int cons;
    int guard;
    cons = cons0;
    guard = 0;
    while (cons < w && guard < 3000) begin
      if (rdy === 1'b1) begin
        check_tile(cons);
        repeat ($urandom_range(0, 2)) tick();
        next_tile = 1'b1;
        tick();
        next_tile = 1'b0;
        cons++;
      end else begin
        tick();
      end
      guard++;
    end
    check("drain_count", cons, w);
    check("done_early", done, 1'b0);
    tick();
    check("done_pulse", done, 1'b1);
    tick();
    check("done_single", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, u_if.weight_mem_rd_en_o, 1'b0);
    check({tag, "_addr"}, u_if.weight_mem_addr_o, 16'h0);
    check({tag, "_ld_row"}, u_if.load_weight_row_o, 1'b0);
    check({tag, "_ld_sel"}, {u_if.load_weight_buf_o, u_if.load_weight_row_sel_o}, 6'h0);
    check({tag, "_ld_data_nz"}, |u_if.load_weight_data_o, 1'b0);
    check({tag, "_rdy"}, rdy, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1;
    start = 1'b0;
    w_tiles = '0;
    w_base = '0;
    next_tile = 1'b0;
    base = '0;
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    rst_i = 1'b0;
    tick();
    tick();
    check("idle_no_read", rd_log.size(), 0);

    // One tile at 0x0100, consumer held off.
    kick(16'h0100, 6'd1);
    check("busy_on_start", busy, 1'b1);
    while (cyc < sc + 33) tick();
    check("rdy_before_last_write", rdy, 1'b0);
    tick();
    check("rdy_after_last_write", rdy, 1'b1);
    while (cyc < sc + 40) tick();
    check("drain_held_busy", busy, 1'b1);
    check("drain_held_done", done, 1'b0);
    check_reads(1, "one_tile");
    // A start while busy is ignored.
    w_base = 16'h0000;
    w_tiles = 6'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("start_ignored_reads", rd_log.size(), MulSize);
    check("start_ignored_rd_en", u_if.weight_mem_rd_en_o, 1'b0);
    drain(1, 0);

    // Three tiles, consumer stalled: both slots fill, then fetch waits.
    kick(16'($urandom), 6'd3);
    repeat (79) tick();
    check("stall_nreads", rd_log.size(), 2 * MulSize);
    check("stall_rd_en", u_if.weight_mem_rd_en_o, 1'b0);
    check("stall_busy", busy, 1'b1);
    check("stall_rdy", rdy, 1'b1);
    drain(3, 0);
    check("resume_addr", rd_log[2 * MulSize], 16'(base + 16'(2 * MulSize)));
    check_reads(3, "stalled");

    // Empty job: no reads, done on the second cycle after start.
    kick(16'h1234, 6'd0);
    check("zero_busy", busy, 1'b1);
    check("zero_done_c1", done, 1'b0);
    tick();
    check("zero_done_c2", done, 1'b1);
    tick();
    check("zero_done_c3", done, 1'b0);
    check("zero_reads", rd_log.size(), 0);

    // Address wrap at the top of memory.
    kick(16'hFFF0, 6'd1);
    drain(1, 0);
    check_reads(1, "wrap");
    check("wrap_zero_addr", rd_log[16], 16'h0000);

    // Asynchronous reset in the middle of tile 1.
    kick(16'($urandom), 6'd3);
    while (cyc < sc + 43) tick();
    check("pre_reset_addr", u_if.weight_mem_addr_o, 16'(base + 16'(MulSize + 10)));
    #2;
    rst_i = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    rd_log.delete();
    rd_cyc.delete();
    repeat (4) tick();
    check("post_reset_quiet", rd_log.size(), 0);
    kick(16'($urandom), 6'd1);
    check("restart_first_addr", u_if.weight_mem_addr_o, base);
    drain(1, 0);
    check_reads(1, "restart");

    // Release lands on the same edge as the other buffer's last-row write.
    kick(16'($urandom), 6'd4);
    while (cyc < sc + 65) tick();
    check("coinc_rdy", rdy, 1'b1);
    check("coinc_last_write", {u_if.load_weight_row_o, u_if.load_weight_buf_o,
                               u_if.load_weight_row_sel_o}, {1'b1, 1'b1, 5'd31});
    check_tile(0);
    next_tile = 1'b1;
    tick();
    next_tile = 1'b0;
    check("coinc_rdy_after", rdy, 1'b1);
    drain(4, 1);
    check_reads(4, "coincide");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
